// File: rtl/hs_multiport_regfile_pkg.sv
// Shared types and slice helpers for the multiport handshake register file.
package hs_regfile_pkg;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_ACKED = 1'b1
    } wr_state_e;

    // LSB of element idx inside a flattened bus of width-bit elements.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/hs_multiport_regfile_wr_port_ctrl.sv
// Four-phase req/ack controller for one write port; commit pulses on the accepting cycle.
module hs_wr_port_ctrl
    import hs_regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic we,
    input  logic addr_ok,
    output logic ack,
    output logic commit
);

    wr_state_e state_q;
    wr_state_e state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit is gated by reset so a write pending at a reset edge is neither stored nor bypassed.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (req) begin
                    state_d = WR_ACKED;
                    commit  = we && addr_ok && rst_n;
                end
            end
            WR_ACKED: begin
                if (!req) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    assign ack = (state_q == WR_ACKED);

endmodule

// File: rtl/hs_multiport_regfile.sv
// Register file with N four-phase write ports, M combinational read ports, priority and bypass.
module hs_multiport_regfile
    import hs_regfile_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int NumRegs    = 16,
    parameter int AddrWidth  = $clog2(NumRegs),
    parameter int NumWrPorts = 2,
    parameter int NumRdPorts = 2,
    parameter int ZeroReg    = 1,
    parameter int Bypass     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumWrPorts-1:0]            wr_req,
    output logic [NumWrPorts-1:0]            wr_ack,
    input  logic [NumWrPorts-1:0]            wr_we,
    input  logic [NumWrPorts*AddrWidth-1:0]  wr_addr,
    input  logic [NumWrPorts*DataWidth-1:0]  wr_data,
    input  logic [NumRdPorts*AddrWidth-1:0]  rd_addr,
    output logic [NumRdPorts*DataWidth-1:0]  rd_data
);

    logic [AddrWidth-1:0]  waddr [NumWrPorts];
    logic [DataWidth-1:0]  wdata [NumWrPorts];
    logic [NumWrPorts-1:0] addr_ok;
    logic [NumWrPorts-1:0] commit;
    logic [DataWidth-1:0]  regs  [NumRegs];

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return 32'(a) < NumRegs;
    endfunction

    function automatic logic is_zero_reg(input logic [AddrWidth-1:0] a);
        return (ZeroReg != 0) && (a == '0);
    endfunction

    for (genvar k = 0; k < NumWrPorts; k++) begin : g_wr
        assign waddr[k]   = wr_addr[slice_lsb(k, AddrWidth) +: AddrWidth];
        assign wdata[k]   = wr_data[slice_lsb(k, DataWidth) +: DataWidth];
        assign addr_ok[k] = in_range(waddr[k]) && !is_zero_reg(waddr[k]);

        hs_wr_port_ctrl u_ctrl (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (wr_req[k]),
            .we      (wr_we[k]),
            .addr_ok (addr_ok[k]),
            .ack     (wr_ack[k]),
            .commit  (commit[k])
        );
    end

    // Ports are visited highest index first so the lowest-index writer lands last and wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = NumWrPorts - 1; k >= 0; k--) begin
                if (commit[k]) begin
                    regs[waddr[k]] <= wdata[k];
                end
            end
        end
    end

    for (genvar j = 0; j < NumRdPorts; j++) begin : g_rd
        logic [AddrWidth-1:0] ra;
        logic [DataWidth-1:0] rd_val;

        assign ra = rd_addr[slice_lsb(j, AddrWidth) +: AddrWidth];

        // Commit already excludes register 0 and out-of-range targets, so bypass never overrides those.
        always_comb begin
            rd_val = '0;
            if (in_range(ra) && !is_zero_reg(ra)) begin
                rd_val = regs[ra];
            end
            if (Bypass != 0) begin
                for (int k = NumWrPorts - 1; k >= 0; k--) begin
                    if (commit[k] && (waddr[k] == ra)) begin
                        rd_val = wdata[k];
                    end
                end
            end
        end

        assign rd_data[slice_lsb(j, DataWidth) +: DataWidth] = rd_val;
    end

endmodule

// File: tb/tb_hs_multiport_regfile.sv
// Directed scoreboard bench: one bypassing and one non-bypassing register file on shared inputs.
module tb_hs_multiport_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_req;
    logic [1:0]  wr_we;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic [1:0]  ack_a, ack_b;
    logic [31:0] rd_a, rd_b;

    logic [3:0]  wa0, wa1, ra0, ra1;
    logic [15:0] wd0, wd1;

    assign wr_addr = {wa1, wa0};
    assign wr_data = {wd1, wd0};
    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    hs_multiport_regfile u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .wr_ack  (ack_a),
        .wr_we   (wr_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_a)
    );

    hs_multiport_regfile #(.Bypass(0)) u_dut_nb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .wr_ack  (ack_b),
        .wr_we   (wr_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_b)
    );

    // Scoreboard kinds: 0 ack (bypass DUT), 1/2 bypass rd port 0/1, 3/4 no-bypass rd port 0/1, 5 ack (no-bypass DUT)
    int          kq[$];
    logic [15:0] vq[$];
    string       nq[$];
    int          vectors    = 0;
    int          miscompares = 0;

    task automatic push(input int kind, input logic [15:0] v, input string name);
        kq.push_back(kind);
        vq.push_back(v);
        nq.push_back(name);
    endtask

    task automatic push_ack(input logic [1:0] v, input string name);
        push(0, {14'b0, v}, name);
        push(5, {14'b0, v}, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int          k;
        logic [15:0] exp_v;
        logic [15:0] act_v;
        string       nm;
        while (kq.size() > 0) begin
            k     = kq.pop_front();
            exp_v = vq.pop_front();
            nm    = nq.pop_front();
            case (k)
                0:       act_v = {14'b0, ack_a};
                1:       act_v = rd_a[15:0];
                2:       act_v = rd_a[31:16];
                3:       act_v = rd_b[15:0];
                4:       act_v = rd_b[31:16];
                5:       act_v = {14'b0, ack_b};
                default: act_v = 'x;
            endcase
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s (kind %0d): got %h expected %h at %0t", nm, k, act_v, exp_v, $time);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        wr_req = 2'b00;
        wr_we  = 2'b00;
        wa0 = 4'd0; wa1 = 4'd0; ra0 = 4'd0; ra1 = 4'd0;
        wd0 = 16'h0; wd1 = 16'h0;
        tick();
        tick();

        // Reset state, then read every address on both read ports
        push_ack(2'b00, "reset_ack");
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) begin
            ra0 = 4'(r);
            ra1 = 4'(15 - r);
            push(1, 16'h0, "reset_rd0");
            push(4, 16'h0, "reset_rd1_nb");
            tick();
        end

        // Single write to reg 5
        wr_req = 2'b01; wr_we = 2'b01; wa0 = 4'd5; wd0 = 16'hBEEF; ra0 = 4'd5;
        push(1, 16'hBEEF, "bypass_first_write");
        push(3, 16'h0000, "nobypass_before_edge");
        push_ack(2'b00, "ack_before_edge");
        tick();
        push_ack(2'b01, "ack_rise");
        push(1, 16'hBEEF, "write_stored");
        push(3, 16'hBEEF, "write_stored_nb");
        wd0 = 16'h1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            push_ack(2'b01, "ack_hold");
            push(1, 16'hBEEF, "hold_no_rewrite");
            push(3, 16'hBEEF, "hold_no_rewrite_nb");
            tick();
        end
        wr_req = 2'b00;
        push_ack(2'b01, "ack_until_edge");
        tick();

        // Same-address collision: port 0 wins
        push_ack(2'b00, "ack_fall");
        wr_req = 2'b11; wr_we = 2'b11; wa0 = 4'd3; wa1 = 4'd3;
        wd0 = 16'hAAAA; wd1 = 16'h5555; ra0 = 4'd3;
        push(1, 16'hAAAA, "bypass_collision");
        push(3, 16'h0000, "nobypass_collision_old");
        tick();
        push_ack(2'b11, "collision_acks");
        push(1, 16'hAAAA, "collision_store");
        push(3, 16'hAAAA, "collision_store_nb");
        wr_req = 2'b00;
        tick();
        tick();

        // Different addresses at one edge
        push_ack(2'b00, "collision_ack_fall");
        wr_req = 2'b11; wa0 = 4'd3; wd0 = 16'h3333; wa1 = 4'd4; wd1 = 16'h4444;
        ra0 = 4'd3; ra1 = 4'd4;
        push(1, 16'h3333, "bypass_dual_p0");
        push(2, 16'h4444, "bypass_dual_p1");
        push(3, 16'hAAAA, "nobypass_dual_old_p0");
        push(4, 16'h0000, "nobypass_dual_old_p1");
        tick();
        push_ack(2'b11, "dual_acks");
        push(1, 16'h3333, "dual_store_p0");
        push(2, 16'h4444, "dual_store_p1");
        push(3, 16'h3333, "dual_store_p0_nb");
        push(4, 16'h4444, "dual_store_p1_nb");
        wr_req = 2'b00;
        tick();
        tick();

        // Write to hardwired-zero register
        push_ack(2'b00, "dual_ack_fall");
        wr_req = 2'b01; wr_we = 2'b01; wa0 = 4'd0; wd0 = 16'h1234; ra0 = 4'd0;
        push(1, 16'h0000, "zero_no_bypass");
        tick();
        push_ack(2'b01, "zero_ack");
        push(1, 16'h0000, "zero_read");
        push(3, 16'h0000, "zero_read_nb");
        wr_req = 2'b00;
        tick();
        tick();

        // Handshake without write enable
        push_ack(2'b00, "zero_ack_fall");
        wr_req = 2'b10; wr_we = 2'b00; wa1 = 4'd7; wd1 = 16'h9999; ra1 = 4'd7;
        push(2, 16'h0000, "we0_no_bypass");
        tick();
        push_ack(2'b10, "we0_ack");
        push(2, 16'h0000, "we0_reg_unchanged");
        push(4, 16'h0000, "we0_reg_unchanged_nb");
        wr_req = 2'b00;
        tick();
        tick();

        // Same-cycle bypass versus registered read
        push_ack(2'b00, "we0_ack_fall");
        wr_req = 2'b10; wr_we = 2'b10; wa1 = 4'd9; wd1 = 16'h0F0F; ra0 = 4'd9;
        push(1, 16'h0F0F, "bypass_same_cycle");
        push(3, 16'h0000, "nobypass_old_value");
        tick();
        push_ack(2'b10, "bypass_ack");
        push(1, 16'h0F0F, "bypass_stored");
        push(3, 16'h0F0F, "nobypass_after_edge");
        wr_req = 2'b00;
        tick();
        tick();

        // Reset coinciding with a request
        push_ack(2'b00, "bypass_ack_fall");
        rst_n = 1'b0;
        wr_req = 2'b01; wr_we = 2'b01; wa0 = 4'd2; wd0 = 16'hFFFF; ra0 = 4'd2; ra1 = 4'd3;
        tick();
        rst_n = 1'b1;
        push_ack(2'b00, "reset_mid_ack");
        push(3, 16'h0000, "reset_mid_reg2_nb");
        push(4, 16'h0000, "reset_clears_reg3_nb");
        push(2, 16'h0000, "reset_clears_reg3");
        push(1, 16'hFFFF, "post_reset_bypass");
        tick();
        push_ack(2'b01, "post_reset_ack");
        push(3, 16'hFFFF, "post_reset_commit_nb");
        push(1, 16'hFFFF, "post_reset_commit");
        wr_req = 2'b00;
        tick();
        tick();
        push_ack(2'b00, "final_ack_fall");
        tick();

        if (kq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", kq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
